// File: rtl/gfx_pkg.sv
// Shared types for the rectangle-fill engine: FSM state encoding and the
// normalised rectangle bounds carried from the clip stage into the emitter.
package gfx_pkg;

  localparam int COORD_BITS = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_EMIT  = 2'd2,
    ST_DONE  = 2'd3
  } fill_state_e;

  typedef struct packed {
    logic [COORD_BITS-1:0] xmin;
    logic [COORD_BITS-1:0] xmax;
    logic [COORD_BITS-1:0] ymin;
    logic [COORD_BITS-1:0] ymax;
  } rect_t;

endpackage

// File: rtl/gfx_rect_fill_if.sv
// Pixel-beat stream from the fill engine to the framebuffer writer
// (valid/ready handshake with coordinate, colour and end-of-rectangle marker).
interface gfx_rect_fill_if #(
  parameter int X_BITS     = 10,
  parameter int Y_BITS     = 9,
  parameter int PIXEL_BITS = 12
);
  logic                  pixel_valid;
  logic                  pixel_ready;
  logic [X_BITS-1:0]     pixel_x;
  logic [Y_BITS-1:0]     pixel_y;
  logic [PIXEL_BITS-1:0] pixel_color;
  logic                  pixel_last;

  modport master (
    output pixel_valid, pixel_x, pixel_y, pixel_color, pixel_last,
    input  pixel_ready
  );

  modport slave (
    input  pixel_valid, pixel_x, pixel_y, pixel_color, pixel_last,
    output pixel_ready
  );
endinterface

// File: rtl/gfx_rect_clip.sv
// Combinational bounds normalisation. With GFX_RECT_FILL_CLIP_EN defined the
// corners are swapped into order and clamped to the framebuffer; otherwise
// they pass through verbatim and reversed bounds flag an empty rectangle.
module gfx_rect_clip
  import gfx_pkg::*;
#(
  parameter int FB_WIDTH  = 640,
  parameter int FB_HEIGHT = 480,
  parameter int X_BITS    = $clog2(FB_WIDTH),
  parameter int Y_BITS    = $clog2(FB_HEIGHT)
) (
  input  logic [X_BITS-1:0] x0,
  input  logic [X_BITS-1:0] x1,
  input  logic [Y_BITS-1:0] y0,
  input  logic [Y_BITS-1:0] y1,
  output rect_t             rect,
  output logic              empty
);

`ifdef GFX_RECT_FILL_CLIP_EN
  localparam logic [X_BITS-1:0] X_LIM = X_BITS'(FB_WIDTH - 1);
  localparam logic [Y_BITS-1:0] Y_LIM = Y_BITS'(FB_HEIGHT - 1);

  logic [X_BITS-1:0] xlo, xhi;
  logic [Y_BITS-1:0] ylo, yhi;

  always_comb begin
    xlo = (x0 > x1) ? x1 : x0;
    xhi = (x0 > x1) ? x0 : x1;
    ylo = (y0 > y1) ? y1 : y0;
    yhi = (y0 > y1) ? y0 : y1;
    // Clamping after the swap keeps lo <= hi, so a clipped rectangle is never empty.
    if (xlo > X_LIM) xlo = X_LIM;
    if (xhi > X_LIM) xhi = X_LIM;
    if (ylo > Y_LIM) ylo = Y_LIM;
    if (yhi > Y_LIM) yhi = Y_LIM;
  end

  assign rect.xmin = COORD_BITS'(xlo);
  assign rect.xmax = COORD_BITS'(xhi);
  assign rect.ymin = COORD_BITS'(ylo);
  assign rect.ymax = COORD_BITS'(yhi);
  assign empty     = 1'b0;
`else
  assign rect.xmin = COORD_BITS'(x0);
  assign rect.xmax = COORD_BITS'(x1);
  assign rect.ymin = COORD_BITS'(y0);
  assign rect.ymax = COORD_BITS'(y1);
  assign empty     = (x0 > x1) || (y0 > y1);
`endif

endmodule

// File: rtl/gfx_rect_fill.sv
// Rectangle fill engine: accepts a fill command, then streams every pixel of
// the rectangle in raster order over a valid/ready beat interface.
// Optional clipping is enabled with the GFX_RECT_FILL_CLIP_EN macro.
module gfx_rect_fill
  import gfx_pkg::*;
#(
  parameter  int FB_WIDTH   = 640,
  parameter  int FB_HEIGHT  = 480,
  parameter  int PIXEL_BITS = 12,
  localparam int X_BITS     = $clog2(FB_WIDTH),
  localparam int Y_BITS     = $clog2(FB_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [X_BITS-1:0]     x0,
  input  logic [X_BITS-1:0]     x1,
  input  logic [Y_BITS-1:0]     y0,
  input  logic [Y_BITS-1:0]     y1,
  input  logic [PIXEL_BITS-1:0] color,
  output logic                  busy,
  output logic                  done,
  gfx_rect_fill_if.master       pix
);

  fill_state_e state, state_nx;

  logic [X_BITS-1:0]     x0_q, x1_q, cur_x;
  logic [Y_BITS-1:0]     y0_q, y1_q, cur_y;
  logic [PIXEL_BITS-1:0] color_q;
  rect_t                 rect_c, rect_q;
  logic                  empty_c;
  logic                  xmax_hit, ymax_hit, beat;

  gfx_rect_clip #(
    .FB_WIDTH  (FB_WIDTH),
    .FB_HEIGHT (FB_HEIGHT),
    .X_BITS    (X_BITS),
    .Y_BITS    (Y_BITS)
  ) u_clip (
    .x0    (x0_q),
    .x1    (x1_q),
    .y0    (y0_q),
    .y1    (y1_q),
    .rect  (rect_c),
    .empty (empty_c)
  );

  assign xmax_hit = (cur_x == rect_q.xmax[X_BITS-1:0]);
  assign ymax_hit = (cur_y == rect_q.ymax[Y_BITS-1:0]);
  assign beat     = (state == ST_EMIT) && pix.pixel_ready;

  always_comb begin
    // NOTE: default first so every path assigns state_nx and no latch is inferred.
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_SETUP;
      ST_SETUP: state_nx = empty_c ? ST_DONE : ST_EMIT;
      ST_EMIT:  if (beat && xmax_hit && ymax_hit) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x0_q    <= '0;
      x1_q    <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
      rect_q  <= '0;
      cur_x   <= '0;
      cur_y   <= '0;
    end else begin
      if (state == ST_IDLE && start) begin
        x0_q    <= x0;
        x1_q    <= x1;
        y0_q    <= y0;
        y1_q    <= y1;
        color_q <= color;
      end
      if (state == ST_SETUP) begin
        rect_q <= rect_c;
        cur_x  <= rect_c.xmin[X_BITS-1:0];
        cur_y  <= rect_c.ymin[Y_BITS-1:0];
      end
      // The final beat leaves the counters parked on (xmax, ymax).
      if (beat) begin
        if (!xmax_hit) begin
          cur_x <= cur_x + 1'b1;
        end else if (!ymax_hit) begin
          cur_x <= rect_q.xmin[X_BITS-1:0];
          cur_y <= cur_y + 1'b1;
        end
      end
    end
  end

  assign busy            = (state != ST_IDLE);
  assign done            = (state == ST_DONE);
  assign pix.pixel_valid = (state == ST_EMIT);
  assign pix.pixel_last  = (state == ST_EMIT) && xmax_hit && ymax_hit;
  assign pix.pixel_x     = cur_x;
  assign pix.pixel_y     = cur_y;
  assign pix.pixel_color = color_q;

endmodule

// File: tb/tb_gfx_rect_fill.sv
// Directed bench for gfx_rect_fill: raster order, stalls, empty/clipped
// rectangles, mid-fill reset and back-to-back starts.
module tb_gfx_rect_fill;

  localparam int X_BITS = 10;
  localparam int Y_BITS = 9;
  localparam int PB     = 12;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [X_BITS-1:0] x0, x1;
  logic [Y_BITS-1:0] y0, y1;
  logic [PB-1:0]     color;
  logic              busy, done;

  int vectors     = 0;
  int miscompares = 0;

  gfx_rect_fill_if #(.X_BITS(X_BITS), .Y_BITS(Y_BITS), .PIXEL_BITS(PB)) pix ();

  gfx_rect_fill #(.FB_WIDTH(640), .FB_HEIGHT(480), .PIXEL_BITS(PB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .x0      (x0),
    .x1      (x1),
    .y0      (y0),
    .y1      (y1),
    .color   (color),
    .busy    (busy),
    .done    (done),
    .pix     (pix)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] beat_word(input int bx, input int by, input bit last,
                                            input logic [PB-1:0] c);
    logic [X_BITS-1:0] xx;
    logic [Y_BITS-1:0] yy;
    xx = X_BITS'(bx);
    yy = Y_BITS'(by);
    return {xx, yy, last, c};
  endfunction

  function automatic logic [31:0] dut_beat();
    return {pix.pixel_x, pix.pixel_y, pix.pixel_last, pix.pixel_color};
  endfunction

  // Issue one fill from an idle cycle (called at posedge+1) and check every
  // cycle through the trailing idle cycle. mode 0: ready held high,
  // mode 1: ready toggles 1/0 starting with 1.
  task automatic fill(input string tag, input int ax0, input int ax1, input int ay0,
                      input int ay1, input logic [PB-1:0] c, input int mode);
    int xa, xb, ya, yb, t, w, n, idx, cyc;
    bit empty, rdy;
    xa = ax0; xb = ax1; ya = ay0; yb = ay1;
`ifdef GFX_RECT_FILL_CLIP_EN
    if (xa > xb) begin t = xa; xa = xb; xb = t; end
    if (ya > yb) begin t = ya; ya = yb; yb = t; end
    if (xa > 639) xa = 639;
    if (xb > 639) xb = 639;
    if (ya > 479) ya = 479;
    if (yb > 479) yb = 479;
    empty = 1'b0;
`else
    empty = (xa > xb) || (ya > yb);
`endif
    w = xb - xa + 1;
    n = empty ? 0 : w * (yb - ya + 1);

    x0 = X_BITS'(ax0); x1 = X_BITS'(ax1);
    y0 = Y_BITS'(ay0); y1 = Y_BITS'(ay1);
    color = c;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    x0 = '0; x1 = '0; y0 = '0; y1 = '0; color = '0;
    check({tag, ":setup"}, {busy, done, pix.pixel_valid}, 3'b100);

    @(posedge clk); #1;
    check({tag, ":first_valid"}, pix.pixel_valid, (n > 0));

    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 400) begin
      rdy = (mode == 0) ? 1'b1 : (cyc % 2 == 0);
      pix.pixel_ready = rdy;
      check({tag, ":valid"}, {busy, pix.pixel_valid}, 2'b11);
      check({tag, ":beat"}, dut_beat(),
            beat_word(xa + idx % w, ya + idx / w, (idx == n - 1), c));
      if (rdy) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, ":beat_count"}, idx, n);
    pix.pixel_ready = 1'b0;
    check({tag, ":done"}, {busy, done, pix.pixel_valid}, 3'b110);
    @(posedge clk); #1;
    check({tag, ":idle"}, {busy, done, pix.pixel_valid}, 3'b000);
  endtask

  initial begin
    logic [10:0] exp_busy, exp_done, exp_valid;
    reset_n = 1'b0;
    start = 1'b0;
    x0 = '0; x1 = '0; y0 = '0; y1 = '0; color = '0;
    pix.pixel_ready = 1'b0;

    #2;
    check("reset_state", {busy, done, pix.pixel_valid, dut_beat()}, '0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    fill("r2x3_ready",  2, 4, 1, 2, 12'hF00, 0);
    fill("r2x3_toggle", 2, 4, 1, 2, 12'hF00, 1);
    fill("r1x1",        5, 5, 7, 7, 12'h0A5, 0);
    fill("rclip_x",   700, 630, 10, 10, 12'h3C3, 0);
    fill("rev_y",       1, 2, 5, 3, 12'h777, 1);
    fill("r4x2",        0, 3, 0, 1, 12'hABC, 1);

    // Mid-fill reset after three of six beats.
    x0 = 10'd2; x1 = 10'd4; y0 = 9'd1; y1 = 9'd2; color = 12'h0F0;
    pix.pixel_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("rst_mid:pos", dut_beat(), beat_word(2, 2, 1'b0, 12'h0F0));
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid:zero", {busy, done, pix.pixel_valid, dut_beat()}, '0);
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_mid:no_done", {busy, done}, 2'b00);
    end
    reset_n = 1'b1;
    pix.pixel_ready = 1'b0;
    @(posedge clk); #1;
    check("rst_mid:idle", {busy, done}, 2'b00);
    fill("after_rst", 2, 4, 1, 2, 12'h0F0, 0);

    // start held high across two 2x1 fills; cycles c1..c11 after first accept.
    exp_busy  = 11'b00111101111;  // bit i = cycle c(i+1)
    exp_done  = 11'b00100001000;
    exp_valid = 11'b00011000110;
    x0 = 10'd0; x1 = 10'd1; y0 = 9'd3; y1 = 9'd3; color = 12'h123;
    pix.pixel_ready = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      if (i == 8) start = 1'b0;
      check($sformatf("b2b:c%0d", i + 1), {busy, done, pix.pixel_valid},
            {exp_busy[i], exp_done[i], exp_valid[i]});
      if (exp_valid[i])
        check($sformatf("b2b:beat_c%0d", i + 1), dut_beat(),
              beat_word((i == 1 || i == 6) ? 0 : 1, 3, (i == 2 || i == 7), 12'h123));
    end
    pix.pixel_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
